// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes and parity modes,
// common to the tx and rx stream blocks.
package uart_pkg;
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is dropped
// even when a pop happens on the same edge.
module uart_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: valid/ready input into a small FIFO, frames
// serialised LSB-first with configurable width, parity and stop bits.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  uart_state_t          r_state;
  logic [BW-1:0]        r_baud;
  logic [IW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par, r_tx;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_full, w_empty, w_tick, w_frame_end, w_load;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_load),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_tick      = (r_baud == BAUD_LAST);
  assign w_frame_end = (r_state == ST_STOP) && w_tick && (r_bit == STOP_LAST);
  // Popping at the end of the last stop bit chains frames with no idle gap.
  assign w_load      = ((r_state == ST_IDLE) || w_frame_end) && !w_empty;
  assign tx_ready    = !w_full;
  assign tx          = r_tx;
  assign busy        = (r_state != ST_IDLE) || !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_baud <= (r_state == ST_IDLE || w_tick) ? '0 : r_baud + 1'b1;
      if (w_load) begin
        r_shift <= w_head;
        r_par   <= ^w_head ^ PAR_INV;
        r_bit   <= '0;
        r_state <= ST_START;
        r_tx    <= 1'b0;
      end else begin
        case (r_state)
          ST_START: if (w_tick) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
          ST_DATA: if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit == DATA_LAST) begin
              r_bit <= '0;
              if (PARITY != PAR_NONE) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_shift[1];
            end
          end
          ST_PARITY: if (w_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
          ST_STOP: if (w_tick) begin
            if (r_bit == STOP_LAST) begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: four instances (8N1, 8E1, 8O1, 8N2) compared per
// cycle against a queue-based line model with randomised producer behaviour.
module tb_uart_tx_stream;
  localparam int CPB   = 4;
  localparam int NI    = 4;
  localparam int DEPTH = 4;
  localparam int PARS [NI] = '{0, 2, 1, 0};
  localparam int STPS [NI] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v   [NI] = '{default: 1'b0};
  logic [7:0] d   [NI] = '{default: 8'h00};
  logic       rdy [NI];
  logic       txl [NI];
  logic       bsy [NI];
  logic [2:0] cnt [NI];

  int cmp = 0;
  int bad = 0;
  int vprob = 100;
  logic [7:0] src[$];
  logic [7:0] mq[$];
  bit         line[$];
  bit e_tx, e_busy, e_rdy;
  int e_cnt;

  always #5 clk = ~clk;

  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
    .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
    .tx(txl[0]), .busy(bsy[0]), .fifo_count(cnt[0]));
  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .tx_data(d[1]), .tx_valid(v[1]), .tx_ready(rdy[1]),
    .tx(txl[1]), .busy(bsy[1]), .fifo_count(cnt[1]));
  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
    .clk(clk), .rst(rst), .tx_data(d[2]), .tx_valid(v[2]), .tx_ready(rdy[2]),
    .tx(txl[2]), .busy(bsy[2]), .fifo_count(cnt[2]));
  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u3 (
    .clk(clk), .rst(rst), .tx_data(d[3]), .tx_valid(v[3]), .tx_ready(rdy[3]),
    .tx(txl[3]), .busy(bsy[3]), .fifo_count(cnt[3]));

  // Expected line levels of one whole frame, one entry per clock cycle.
  function automatic void load_frame(int k, logic [7:0] w);
    repeat (CPB) line.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) line.push_back(w[i]);
    if (PARS[k] != 0) repeat (CPB) line.push_back((^w) ^ (PARS[k] == 1));
    repeat (STPS[k] * CPB) line.push_back(1'b1);
  endfunction

  task automatic drive(int k);
    v[k] = (src.size() > 0) && ($urandom_range(0, 99) < vprob);
    d[k] = v[k] ? src[0] : 8'($urandom);
  endtask

  task automatic model_clear();
    src.delete(); mq.delete(); line.delete();
  endtask

  // One clock: advance the model over the edge, drive next inputs, settle at negedge.
  task automatic tick(int k);
    bit full, act;
    @(posedge clk);
    full = (mq.size() >= DEPTH);
    if (line.size() == 0 && mq.size() > 0) load_frame(k, mq.pop_front());
    if (v[k] && !full) mq.push_back(src.pop_front());
    act    = (line.size() > 0);
    e_tx   = act ? line.pop_front() : 1'b1;
    e_busy = act || (mq.size() > 0);
    e_rdy  = (mq.size() < DEPTH);
    e_cnt  = mq.size();
    #1 drive(k);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      cmp++;
      if ({txl[k], rdy[k], bsy[k], cnt[k]} !== 6'b110_000) begin
        bad++;
        $display("FAIL reset_state inst %0d: tx/ready/busy/count got %b expected 110000", k, {txl[k], rdy[k], bsy[k], cnt[k]});
      end
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cmp++;
      if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc %0d: tx=%b busy=%b expected tx=1 busy=0", c, txl[0], bsy[0]);
      end
    end
  endtask

  task automatic test_frame_8n1();
    bit pat [10] = '{0, 0, 1, 0, 1, 0, 0, 1, 1, 1};
    int nbusy = 0;
    model_clear(); vprob = 100; src.push_back(8'hCA); drive(0);
    for (int c = 0; c < 60; c++) begin
      tick(0);
      nbusy += int'(bsy[0]);
      cmp++;
      if ({txl[0], bsy[0], rdy[0], cnt[0]} !== {e_tx, e_busy, e_rdy, 3'(e_cnt)}) begin
        bad++;
        $display("FAIL frame8n1 cyc %0d: tx/busy/ready/count got %b expected %b", c, {txl[0], bsy[0], rdy[0], cnt[0]}, {e_tx, e_busy, e_rdy, 3'(e_cnt)});
      end
      if (c >= 1 && c <= 40) begin
        cmp++;
        if (txl[0] !== pat[(c - 1) / CPB]) begin
          bad++;
          $display("FAIL frame8n1_pattern cyc %0d: tx got %b expected %b", c, txl[0], pat[(c - 1) / CPB]);
        end
      end
    end
    cmp++;
    if (nbusy != 41) begin
      bad++;
      $display("FAIL frame8n1_busy_cycles: got %0d expected 41", nbusy);
    end
  endtask

  task automatic test_parity();
    for (int k = 1; k <= 2; k++) begin
      int nbusy = 0;
      model_clear(); vprob = 100; src.push_back(8'hCA); drive(k);
      for (int c = 0; c < 60; c++) begin
        tick(k);
        nbusy += int'(bsy[k]);
        cmp++;
        if ({txl[k], bsy[k], rdy[k], cnt[k]} !== {e_tx, e_busy, e_rdy, 3'(e_cnt)}) begin
          bad++;
          $display("FAIL parity inst %0d cyc %0d: tx/busy/ready/count got %b expected %b", k, c, {txl[k], bsy[k], rdy[k], cnt[k]}, {e_tx, e_busy, e_rdy, 3'(e_cnt)});
        end
        if (c == 38) begin
          cmp++;
          if (txl[k] !== (k == 2)) begin
            bad++;
            $display("FAIL parity_bit inst %0d: got %b expected %b", k, txl[k], (k == 2));
          end
        end
      end
      cmp++;
      if (nbusy != 45) begin
        bad++;
        $display("FAIL parity_busy_cycles inst %0d: got %0d expected 45", k, nbusy);
      end
    end
  endtask

  task automatic test_fifo_full();
    model_clear(); vprob = 100;
    for (int i = 1; i <= 6; i++) src.push_back(8'(i));
    drive(0);
    for (int c = 0; c < 260; c++) begin
      tick(0);
      cmp++;
      if ({txl[0], bsy[0], rdy[0], cnt[0]} !== {e_tx, e_busy, e_rdy, 3'(e_cnt)}) begin
        bad++;
        $display("FAIL fifo_full cyc %0d: tx/busy/ready/count got %b expected %b", c, {txl[0], bsy[0], rdy[0], cnt[0]}, {e_tx, e_busy, e_rdy, 3'(e_cnt)});
      end
      if (c == 4) begin
        cmp++;
        if (rdy[0] !== 1'b0 || cnt[0] !== 3'd4) begin
          bad++;
          $display("FAIL fifo_full_edge5: ready=%b count=%0d expected ready=0 count=4", rdy[0], cnt[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nbusy = 0;
    model_clear(); vprob = 100;
    src.push_back(8'h55); src.push_back(8'hB2);
    drive(3);
    for (int c = 0; c < 100; c++) begin
      tick(3);
      nbusy += int'(bsy[3]);
      cmp++;
      if ({txl[3], bsy[3], rdy[3], cnt[3]} !== {e_tx, e_busy, e_rdy, 3'(e_cnt)}) begin
        bad++;
        $display("FAIL back_to_back cyc %0d: tx/busy/ready/count got %b expected %b", c, {txl[3], bsy[3], rdy[3], cnt[3]}, {e_tx, e_busy, e_rdy, 3'(e_cnt)});
      end
    end
    cmp++;
    if (nbusy != 89) begin
      bad++;
      $display("FAIL back_to_back_busy_cycles: got %0d expected 89", nbusy);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int k = $urandom_range(0, NI - 1);
      bit done = 0;
      model_clear(); vprob = 50;
      repeat ($urandom_range(4, 7)) src.push_back(8'($urandom));
      drive(k);
      for (int c = 0; c < 3000 && !done; c++) begin
        tick(k);
        cmp++;
        if ({txl[k], bsy[k], rdy[k], cnt[k]} !== {e_tx, e_busy, e_rdy, 3'(e_cnt)}) begin
          bad++;
          $display("FAIL random r%0d inst %0d cyc %0d: tx/busy/ready/count got %b expected %b", r, k, c, {txl[k], bsy[k], rdy[k], cnt[k]}, {e_tx, e_busy, e_rdy, 3'(e_cnt)});
        end
        done = (src.size() == 0 && mq.size() == 0 && line.size() == 0);
      end
      cmp++;
      if (!done) begin
        bad++;
        $display("FAIL random_timeout r%0d: stream not drained, got %0d pending expected 0", r, src.size() + mq.size());
      end
    end
    vprob = 100;
  endtask

  task automatic test_reset_mid();
    model_clear(); vprob = 100;
    src.push_back(8'hCA); src.push_back(8'h11); src.push_back(8'h22);
    drive(0);
    for (int c = 0; c < 9; c++) begin
      tick(0);
      cmp++;
      if ({txl[0], bsy[0], rdy[0], cnt[0]} !== {e_tx, e_busy, e_rdy, 3'(e_cnt)}) begin
        bad++;
        $display("FAIL reset_mid_pre cyc %0d: tx/busy/ready/count got %b expected %b", c, {txl[0], bsy[0], rdy[0], cnt[0]}, {e_tx, e_busy, e_rdy, 3'(e_cnt)});
      end
    end
    v[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp++;
    if ({txl[0], cnt[0], rdy[0]} !== 5'b1_000_1) begin
      bad++;
      $display("FAIL reset_mid_async: tx/count/ready got %b expected 10001", {txl[0], cnt[0], rdy[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 100; c++) begin
      tick(0);
      cmp++;
      if ({txl[0], bsy[0], rdy[0], cnt[0]} !== {e_tx, e_busy, e_rdy, 3'(e_cnt)}) begin
        bad++;
        $display("FAIL reset_mid_post cyc %0d: tx/busy/ready/count got %b expected %b", c, {txl[0], bsy[0], rdy[0], cnt[0]}, {e_tx, e_busy, e_rdy, 3'(e_cnt)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_8n1();
    test_parity();
    test_fifo_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter, successor to the fixed-pattern sender in the soil-monitoring bot. It accepts words from any producer over a valid/ready handshake and buffers them in a small FIFO. Each word is serialised LSB-first with a programmable bit period, data width, parity and stop-bit count. It drives the board TX pin (sensor telemetry to the host/radio module) and replaces hard-coded byte sequences with a streaming interface.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200); legal ≥ 2.
- DATA_BITS, default 8: data bits per frame; legal 5–9.
- PARITY, default 0: 0 none, 1 odd, 2 even.
- STOP_BITS, default 1: legal 1 or 2.
- FIFO_DEPTH, default 4: FIFO entries; power of 2, ≥ 2.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  FIFO not full; word accepted on an edge where tx_valid && tx_ready.
- tx  out  1  serial line; idle high.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries currently in FIFO.

## Operation
- Reset values: tx=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE, FIFO empty, bit and baud counters 0.
- FSM states: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE or START.
- IDLE: tx=1; if FIFO non-empty, pop head into shift register, latch parity bit, go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0] each bit, LSB first; shift right at each bit boundary; DATA_BITS bits counted by bit index.
- PARITY: even = XOR of data word; odd = its inverse; one bit period.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. At end, if FIFO non-empty, pop and go directly to START (zero idle gap); else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, restarts at every state/bit boundary; width $clog2(CLKS_PER_BIT).
- FIFO: push when tx_valid && tx_ready; pop only from FSM. Full → tx_ready=0 combinationally from count; a push attempted when full is ignored even if a pop occurs on the same edge. Simultaneous push+pop when not full/empty: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- tx_data is ignored when tx_valid=0. tx_valid need not stay asserted after acceptance.
- Reset asserted mid-frame: tx goes high immediately (asynchronous), frame is aborted, FIFO contents are discarded.

## Timing
- tx is a registered output; no combinational path from inputs to tx.
- Latency: word accepted at edge N into empty FIFO with FSM IDLE → popped at edge N+1, tx low from edge N+1.
- Frame length exactly (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles; every bit exactly CLKS_PER_BIT cycles.
- fifo_count and tx_ready update on the edge of push/pop; busy falls on the edge the FSM returns to IDLE with FIFO empty.
- Throughput: continuous frames with no gap while FIFO remains non-empty.

## Structure
- Package uart_pkg: FSM state enum, parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), shared with the future uart_rx_stream.
- Sub-module uart_tx_fifo (synchronous FIFO, parametrised width/depth, count output); top holds FSM, baud counter, shift register.

## Test plan
- Reset: hold rst 3 cycles, then release → tx=1, tx_ready=1, busy=0, fifo_count=0; tx stays 1 for 100 cycles with no valid.
- CLKS_PER_BIT=4, 8N1, push 0xCA → starting one edge after accept, tx per 4-cycle bit: 0 | 0,1,0,1,0,0,1,1 | 1; frame 40 cycles; busy then falls.
- PARITY=2, then 1, send 0xCA → parity bit 0 (even), 1 (odd); frame 44 cycles.
- FIFO_DEPTH=4, tx_valid held high from idle with 0x01..0x06 → 0x01–0x05 accepted, tx_ready low after fifth edge, 0x06 held until a pop; all bytes emitted in order.
- STOP_BITS=2, push 0x55 and 0xB2 back-to-back → 8 stop cycles then next start bit with no extra idle cycle.
- Assert rst mid-data-bit of 0xCA with 2 words queued → tx=1 immediately, fifo_count=0, no further frames after release.
